// File: rtl/kalman_mac_engine_pkg.sv
// Shared definitions for the steady-state Kalman update engine.
// Holds the default Mem1 layout, the sweep FSM states and the saturation helpers.
package kalman_mac_engine_pkg;

    localparam int DEF_N_STATES  = 8;
    localparam int DEF_N_MEAS    = 8;
    localparam int DEF_ROW_STRIDE = DEF_N_STATES + DEF_N_MEAS;
    localparam int DEF_MEAS_BASE = 128;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_DRAIN,
        S_WRITE
    } state_t;

    // Clamp a full-width accumulator value into the 18-bit state range.
    function automatic logic signed [17:0] sat18(input logic signed [53:0] v);
        if (v[53:17] == {37{v[53]}}) begin
            return v[17:0];
        end
        return v[53] ? 18'sh20000 : 18'sh1FFFF;
    endfunction

    function automatic logic signed [35:0] sat36(input logic signed [53:0] v);
        if (v[53:35] == {19{v[53]}}) begin
            return v[35:0];
        end
        return v[53] ? 36'sh8_0000_0000 : 36'sh7_FFFF_FFFF;
    endfunction

endpackage

// File: rtl/kalman_mac_engine_mac54.sv
// Registered 18x18 signed multiplier feeding a 54-bit wrapping accumulator.
// The accumulator can be preloaded from the cascade input at the start of each row.
module kalman_mac54 (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               operand_valid,
    input  logic signed [17:0] a,
    input  logic signed [17:0] b,
    input  logic        [53:0] cin,
    output logic        [53:0] acc_next
);

    logic signed [35:0] prod_q;
    logic               prod_valid;
    logic        [53:0] acc;

    // acc_next exposes the sum that will be registered, so the final row value is usable one cycle early.
    always_comb begin
        acc_next = acc;
        if (prod_valid) begin
            acc_next = acc + {{18{prod_q[35]}}, prod_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q     <= '0;
            prod_valid <= 1'b0;
            acc        <= '0;
        end else begin
            prod_q     <= $signed({{18{a[17]}}, a}) * $signed({{18{b[17]}}, b});
            prod_valid <= operand_valid;
            acc        <= load ? cin : acc_next;
        end
    end

endmodule

// File: rtl/kalman_mac_engine.sv
// Kalman update engine: x_new = A*x + K*z, one row per sweep pass, results streamed to Mem2.
// Coefficients and measurements live in a local dual-read RAM written from the EMIF side.
module kalman_mac_engine
    import kalman_mac_engine_pkg::*;
#(
    parameter int MEM1_AW   = 9,
    parameter int N_STATES  = DEF_N_STATES,
    parameter int N_MEAS    = DEF_N_MEAS,
    parameter int FRAC      = 16,
    parameter int MEAS_BASE = DEF_MEAS_BASE,
    parameter int MEM2_BASE = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        Mem1_data_i,
    input  logic [MEM1_AW-1:0] Mem1_addrw_i,
    input  logic               Mem1_clk_w,
    input  logic               Mem1_clk_en_w,
    input  logic               Mem1_we_i,
    input  logic               enable_i,
    output logic [8:0]         Mem2_addrw_o,
    output logic               Mem2_we_o,
    output logic [35:0]        Mem2_data_o,
    output logic               WIP_flag_o,
    input  logic [53:0]        CIN,
    input  logic               SIGNEDCIN,
    output logic [53:0]        CO,
    output logic               SIGNEDCO
);

    localparam int ROW_LEN = N_STATES + N_MEAS;
    localparam int COL_W   = $clog2(ROW_LEN + 1);
    localparam int ROW_W   = $clog2(N_STATES);

    state_t             state, state_n;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic               en_q, en_prev;
    logic               issue, load;

    logic        [17:0]       mem1 [2**MEM1_AW];
    logic        [MEM1_AW-1:0] coef_addr, meas_addr;
    logic signed [17:0]       coef_q, meas_q;
    logic                     rd_valid, rd_meas;
    logic        [ROW_W-1:0]  rd_xidx;
    logic signed [17:0]       b_op;

    logic signed [17:0] x      [N_STATES];
    logic signed [17:0] x_next [N_STATES];

    logic        [53:0] acc_next;
    logic signed [53:0] result;
    logic               unused_data_bits;

    assign unused_data_bits = ^Mem1_data_i[31:18];
    assign SIGNEDCO   = 1'b1;
    assign WIP_flag_o = (state != S_IDLE);

    always_ff @(posedge clk_i) begin
        if (Mem1_clk_w & Mem1_clk_en_w & Mem1_we_i) begin
            mem1[Mem1_addrw_i] <= Mem1_data_i[17:0];
        end
    end

    // Coefficient and measurement are fetched together; the measurement read is ignored for A columns.
    always_comb begin
        coef_addr = MEM1_AW'(int'(row) * ROW_LEN + int'(col));
        meas_addr = MEM1_AW'(MEAS_BASE + int'(col) - N_STATES);
    end

    always_ff @(posedge clk_i) begin
        coef_q <= mem1[coef_addr];
        meas_q <= mem1[meas_addr];
    end

    always_comb begin
        b_op = rd_meas ? meas_q : x[rd_xidx];
    end

    always_comb begin
        state_n = state;
        issue   = 1'b0;
        load    = 1'b0;
        case (state)
            S_IDLE: begin
                if (en_q && !en_prev) begin
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                load    = 1'b1;
                issue   = 1'b1;
                state_n = S_MAC;
            end
            S_MAC: begin
                issue = (col < COL_W'(ROW_LEN));
                if (col == COL_W'(ROW_LEN)) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: state_n = S_WRITE;
            S_WRITE: begin
                state_n = (row == ROW_W'(N_STATES - 1)) ? S_IDLE : S_LOAD;
            end
            default: state_n = S_IDLE;
        endcase
    end

    kalman_mac54 u_mac (
        .clk           (clk_i),
        .rst           (rst_i),
        .load          (load),
        .operand_valid (rd_valid),
        .a             (coef_q),
        .b             (b_op),
        .cin           (SIGNEDCIN ? CIN : 54'd0),
        .acc_next      (acc_next)
    );

    assign result = $signed(acc_next) >>> FRAC;

    // Outputs are registered from acc_next in DRAIN so they are presented during the WRITE cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            row          <= '0;
            col          <= '0;
            en_q         <= 1'b0;
            en_prev      <= 1'b0;
            rd_valid     <= 1'b0;
            rd_meas      <= 1'b0;
            rd_xidx      <= '0;
            Mem2_we_o    <= 1'b0;
            Mem2_addrw_o <= '0;
            Mem2_data_o  <= '0;
            CO           <= '0;
            for (int i = 0; i < N_STATES; i++) begin
                x[i]      <= '0;
                x_next[i] <= '0;
            end
        end else begin
            state    <= state_n;
            en_q     <= enable_i;
            en_prev  <= en_q;
            rd_valid <= issue;
            rd_meas  <= (col >= COL_W'(N_STATES));
            rd_xidx  <= ROW_W'(col);
            col      <= (state == S_LOAD || state == S_MAC) ? col + COL_W'(1) : '0;
            Mem2_we_o <= 1'b0;
            if (state == S_DRAIN) begin
                Mem2_we_o    <= 1'b1;
                Mem2_addrw_o <= 9'(MEM2_BASE + int'(row));
                Mem2_data_o  <= sat36(result);
                CO           <= acc_next;
                x_next[row]  <= sat18(result);
            end
            if (state == S_WRITE) begin
                if (row == ROW_W'(N_STATES - 1)) begin
                    row <= '0;
                    x   <= x_next;
                end else begin
                    row <= row + ROW_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_kalman_mac_engine.sv
// Self-checking bench for kalman_mac_engine: directed and randomized runs against a
// plain-arithmetic model of x_new = A*x + K*z with cascade preload, wrap and saturation.
module tb_kalman_mac_engine;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] Mem1_data_i;
    logic [8:0]  Mem1_addrw_i;
    logic        Mem1_clk_w, Mem1_clk_en_w, Mem1_we_i;
    logic        enable_i;
    logic [8:0]  Mem2_addrw_o;
    logic        Mem2_we_o;
    logic [35:0] Mem2_data_o;
    logic        WIP_flag_o;
    logic [53:0] CIN;
    logic        SIGNEDCIN;
    logic [53:0] CO;
    logic        SIGNEDCO;

    int     tests_run = 0;
    int     tests_failed = 0;
    int     a_m [8][8];
    int     k_m [8][8];
    int     z_m [8];
    longint x_m [8];
    longint cin_m;
    bit     scin_m;

    int     wr_addr [$];
    longint wr_data [$];
    int     wr_cyc  [$];
    int     wip_cnt = 0;
    int     cyc = 0;

    kalman_mac_engine dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .Mem1_data_i   (Mem1_data_i),
        .Mem1_addrw_i  (Mem1_addrw_i),
        .Mem1_clk_w    (Mem1_clk_w),
        .Mem1_clk_en_w (Mem1_clk_en_w),
        .Mem1_we_i     (Mem1_we_i),
        .enable_i      (enable_i),
        .Mem2_addrw_o  (Mem2_addrw_o),
        .Mem2_we_o     (Mem2_we_o),
        .Mem2_data_o   (Mem2_data_o),
        .WIP_flag_o    (WIP_flag_o),
        .CIN           (CIN),
        .SIGNEDCIN     (SIGNEDCIN),
        .CO            (CO),
        .SIGNEDCO      (SIGNEDCO)
    );

    initial forever #5 clk_i = ~clk_i;

    // Passive monitor: logs every Mem2 write and counts busy cycles.
    always @(negedge clk_i) begin
        if (Mem2_we_o) begin
            wr_addr.push_back(int'(Mem2_addrw_o));
            wr_data.push_back(longint'($signed(Mem2_data_o)));
            wr_cyc.push_back(cyc);
        end
        if (WIP_flag_o) wip_cnt++;
        cyc++;
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic longint wrap54(input longint v);
        return (v <<< 10) >>> 10;
    endfunction

    function automatic longint clampv(input longint v, input longint lo, input longint hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic longint rowAcc(input int r);
        longint acc;
        acc = scin_m ? cin_m : 64'sd0;
        for (int c = 0; c < 8; c++) acc += longint'(a_m[r][c]) * x_m[c];
        for (int m = 0; m < 8; m++) acc += longint'(k_m[r][m]) * z_m[m];
        return wrap54(acc);
    endfunction

    task automatic writeMem(input int addr, input int val, input bit clkw, input bit en, input bit we);
        Mem1_addrw_i  = 9'(addr);
        Mem1_data_i   = {14'($urandom), val[17:0]};
        Mem1_clk_w    = clkw;
        Mem1_clk_en_w = en;
        Mem1_we_i     = we;
        tick();
        Mem1_clk_w    = 1'b0;
        Mem1_clk_en_w = 1'b0;
        Mem1_we_i     = 1'b0;
    endtask

    task automatic writeAll();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) writeMem(r * 16 + c, a_m[r][c], 1'b1, 1'b1, 1'b1);
            for (int m = 0; m < 8; m++) writeMem(r * 16 + 8 + m, k_m[r][m], 1'b1, 1'b1, 1'b1);
        end
        for (int m = 0; m < 8; m++) writeMem(128 + m, z_m[m], 1'b1, 1'b1, 1'b1);
    endtask

    task automatic setCascade(input longint c, input bit s);
        cin_m     = wrap54(c);
        scin_m    = s;
        CIN       = 54'(cin_m);
        SIGNEDCIN = s;
    endtask

    task automatic setMatrices(input int a_diag, input int k_diag);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                a_m[r][c] = (r == c) ? a_diag : 0;
                k_m[r][c] = (r == c) ? k_diag : 0;
            end
        end
    endtask

    function automatic int rnd18();
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    // One complete run: rising enable, wait for completion, check all rows, then commit the model state.
    task automatic applyStimulus(input string tag, input bit toggle_mid);
        int     base_w, base_wip, n;
        longint exp_acc [8];
        longint exp_x [8];
        base_w   = wr_addr.size();
        base_wip = wip_cnt;
        for (int r = 0; r < 8; r++) begin
            exp_acc[r] = rowAcc(r);
            exp_x[r]   = clampv(exp_acc[r] >>> 16, -131072, 131071);
        end
        enable_i = 1'b1;
        if (toggle_mid) begin
            repeat (40) tick();
            enable_i = 1'b0;
            repeat (3) tick();
            enable_i = 1'b1;
            repeat (3) tick();
            enable_i = 1'b0;
        end else begin
            repeat (2) tick();
            enable_i = 1'b0;
        end
        for (int i = 0; i < 400 && !(wip_cnt > base_wip && !WIP_flag_o); i++) tick();
        checkOutput({tag, "/done"}, longint'(WIP_flag_o), 0);
        checkOutput({tag, "/wip_width"}, wip_cnt - base_wip, 152);
        n = wr_addr.size() - base_w;
        checkOutput({tag, "/writes"}, n, 8);
        for (int r = 0; r < 8 && r < n; r++) begin
            checkOutput($sformatf("%s/addr%0d", tag, r), wr_addr[base_w + r], r);
            checkOutput($sformatf("%s/data%0d", tag, r), wr_data[base_w + r],
                        clampv(exp_acc[r] >>> 16, -(64'sd1 <<< 35), (64'sd1 <<< 35) - 1));
            if (r > 0) checkOutput($sformatf("%s/gap%0d", tag, r),
                                   wr_cyc[base_w + r] - wr_cyc[base_w + r - 1], 19);
        end
        checkOutput({tag, "/co"}, longint'($signed(CO)), exp_acc[7]);
        if (toggle_mid) begin
            repeat (30) tick();
            checkOutput({tag, "/no_restart"}, longint'(WIP_flag_o), 0);
            checkOutput({tag, "/no_extra"}, wr_addr.size() - base_w, 8);
        end
        for (int r = 0; r < 8; r++) x_m[r] = exp_x[r];
    endtask

    initial begin
        int base_w;
        rst_i = 1'b1;
        enable_i = 1'b0;
        Mem1_data_i = '0;
        Mem1_addrw_i = '0;
        Mem1_clk_w = 1'b0;
        Mem1_clk_en_w = 1'b0;
        Mem1_we_i = 1'b0;
        for (int r = 0; r < 8; r++) begin
            x_m[r] = 0;
            z_m[r] = 0;
        end
        setCascade(0, 1'b1);
        setMatrices(0, 0);
        repeat (3) tick();
        checkOutput("reset/wip", longint'(WIP_flag_o), 0);
        checkOutput("reset/we", longint'(Mem2_we_o), 0);
        checkOutput("reset/addr", longint'(Mem2_addrw_o), 0);
        checkOutput("reset/data", longint'(Mem2_data_o), 0);
        checkOutput("reset/co", longint'(CO), 0);
        checkOutput("reset/signedco", longint'(SIGNEDCO), 1);
        rst_i = 1'b0;
        tick();
        checkOutput("post_reset/wip", longint'(WIP_flag_o), 0);

        writeAll();
        applyStimulus("zero", 1'b0);

        setMatrices(0, 65536);
        for (int m = 0; m < 8; m++) z_m[m] = 1000 * m;
        writeAll();
        applyStimulus("k_ident", 1'b0);

        setMatrices(65536, 65536);
        writeAll();
        applyStimulus("a_k_ident", 1'b0);

        for (int m = 0; m < 8; m++) z_m[m] = 131071;
        writeAll();
        applyStimulus("sat_run1", 1'b0);
        applyStimulus("sat_run2", 1'b0);

        setMatrices(0, 0);
        for (int m = 0; m < 8; m++) z_m[m] = 0;
        writeAll();
        setCascade(5 * 65536, 1'b1);
        applyStimulus("cascade_on", 1'b0);
        setCascade(5 * 65536, 1'b0);
        applyStimulus("cascade_off", 1'b0);

        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                a_m[r][c] = rnd18();
                k_m[r][c] = rnd18();
            end
            z_m[r] = rnd18();
        end
        writeAll();
        setCascade(longint'({$urandom(), $urandom()}), 1'b1);
        applyStimulus("random1", 1'b0);

        writeMem(128, 12345, 1'b1, 1'b1, 1'b0);
        writeMem(128, 23456, 1'b1, 1'b0, 1'b1);
        writeMem(128, 34567, 1'b0, 1'b1, 1'b1);
        for (int r = 0; r < 8; r++) a_m[r][r] = rnd18();
        for (int r = 0; r < 8; r++) writeMem(r * 16 + r, a_m[r][r], 1'b1, 1'b1, 1'b1);
        setCascade(longint'({$urandom(), $urandom()}), 1'(($urandom() & 1)));
        applyStimulus("random2", 1'b0);

        applyStimulus("toggle_mid", 1'b1);

        setMatrices(0, 0);
        for (int r = 0; r < 8; r++) begin
            for (int m = 0; m < 8; m++) k_m[r][m] = rnd18();
            z_m[r] = rnd18();
        end
        writeAll();
        setCascade(longint'($urandom()), 1'b1);
        base_w = wr_addr.size();
        enable_i = 1'b1;
        repeat (2) tick();
        enable_i = 1'b0;
        for (int i = 0; i < 300 && wr_addr.size() - base_w < 3; i++) tick();
        checkOutput("rst_mid/rows_before", wr_addr.size() - base_w, 3);
        repeat (5) tick();
        rst_i = 1'b1;
        tick();
        checkOutput("rst_mid/wip", longint'(WIP_flag_o), 0);
        checkOutput("rst_mid/we", longint'(Mem2_we_o), 0);
        checkOutput("rst_mid/co", longint'(CO), 0);
        rst_i = 1'b0;
        repeat (30) tick();
        checkOutput("rst_mid/stays_idle", longint'(WIP_flag_o), 0);
        checkOutput("rst_mid/no_writes", wr_addr.size() - base_w, 3);
        applyStimulus("after_rst", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
